// File: rtl/video_timing_pkg.sv
// Video timing package: mode presets, colour-bar table and the control-word
// record that travels down the output delay line.
// Optional feature macro: VIDEO_TIMING_TEST_PATTERN_EN adds the colour-bar
// index to the control word.
package video_timing_pkg;

  // One axis of a video mode: active, front porch, sync, back porch.
  typedef struct packed {
    int unsigned act;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  localparam axis_timing_t H_720P60  = '{act: 1280, front: 72, sync: 80, back: 216};
  localparam axis_timing_t V_720P60  = '{act: 720,  front: 3,  sync: 5,  back: 22};
  localparam axis_timing_t H_1080P60 = '{act: 1920, front: 88, sync: 44, back: 148};
  localparam axis_timing_t V_1080P60 = '{act: 1080, front: 4,  sync: 5,  back: 36};
  localparam axis_timing_t H_480P60  = '{act: 640,  front: 16, sync: 96, back: 48};
  localparam axis_timing_t V_480P60  = '{act: 480,  front: 10, sync: 2,  back: 33};

  localparam int unsigned NUM_BARS = 8;

  // {r,g,b} per bar, index 0 = leftmost: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [NUM_BARS-1:0][23:0] COLOUR_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // Control terms delayed together so they stay aligned with pixel data.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic h_blank;
    logic v_blank;
    logic frame_start;
    logic line_start;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } video_ctl_t;

  // Blanking-state control word for the given sync polarities.
  function automatic video_ctl_t ctl_idle(input logic hs_pol, input logic vs_pol);
    video_ctl_t c;
    c         = '0;
    c.hs      = ~hs_pol;
    c.vs      = ~vs_pol;
    c.h_blank = 1'b1;
    c.v_blank = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: wrapping position counter plus active / sync window flags.
// Ports: clk, reset (async, active-high), clear (sync to 0), adv (step),
//        cnt (position), active_c / sync_c (combinational window flags).
module video_axis_counter #(
  parameter int unsigned ACT   = 1280,
  parameter int unsigned FRONT = 72,
  parameter int unsigned SYNC  = 80,
  parameter int unsigned BACK  = 216,
  parameter int unsigned CW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          active_c,
  output logic          sync_c
);

  localparam int unsigned TOTAL = ACT + FRONT + SYNC + BACK;

  localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END   = CW'(ACT);
  localparam logic [CW-1:0] SYNC_BEG  = CW'(ACT + FRONT);
  localparam logic [CW-1:0] SYNC_LAST = CW'(ACT + FRONT + SYNC - 1);

  if (64'(TOTAL) > (64'd1 << CW)) begin : g_total_too_wide
    $error("video_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
  end

  // Position counter, wraps after the back porch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign active_c = (cnt < ACT_END);
  assign sync_c   = (cnt >= SYNC_BEG) && (cnt <= SYNC_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters, pixel request, aligned sync /
// blanking / data-enable outputs and registered pixel data.
// Ports: clk, reset (async, active-high), enable (sync clear to frame origin),
//        r/g/b + tp_sel in; req/req_x/req_y (combinational request);
//        vga_* video outputs, frame_start / line_start markers (registered).
// Optional feature macro: VIDEO_TIMING_TEST_PATTERN_EN (tp_sel colour bars).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACT    = 1280,
  parameter int unsigned H_FRONT  = 72,
  parameter int unsigned H_SYNC   = 80,
  parameter int unsigned H_BACK   = 216,
  parameter int unsigned V_ACT    = 720,
  parameter int unsigned V_FRONT  = 3,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 22,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned REQ_LEAD = 2,
  parameter int unsigned CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  input  logic          tp_sel,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic          vga_h_blank,
  output logic          vga_v_blank,
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned DEPTH   = REQ_LEAD + 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam video_ctl_t    CTL_IDLE = ctl_idle(HS_POL, VS_POL);

  if (REQ_LEAD > 7) begin : g_lead_range
    $error("video_timing_gen: REQ_LEAD %0d outside 0..7", REQ_LEAD);
  end

  logic          running;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_act_c;
  logic          h_sync_c;
  logic          v_act_c;
  logic          v_sync_c;
  logic          h_wrap_c;
  video_ctl_t    raw_c;
  video_ctl_t    pipe_q [DEPTH];
  logic          tap_de_c;
  logic [23:0]   pix_c;
  logic [23:0]   rgb_q;

  // Counting starts one clock after enable, so the first request is (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
    end else begin
      running <= enable;
    end
  end

  assign h_wrap_c = (h_cnt == H_LAST);

  video_axis_counter #(
    .ACT(H_ACT), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enable),
    .adv      (running),
    .cnt      (h_cnt),
    .active_c (h_act_c),
    .sync_c   (h_sync_c)
  );

  video_axis_counter #(
    .ACT(V_ACT), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enable),
    .adv      (running && h_wrap_c),
    .cnt      (v_cnt),
    .active_c (v_act_c),
    .sync_c   (v_sync_c)
  );

  // Pixel request straight from the counters.
  assign req   = running && h_act_c && v_act_c;
  assign req_x = req ? h_cnt : '0;
  assign req_y = req ? v_cnt : '0;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACT >= NUM_BARS) ? H_ACT / NUM_BARS : 1;

  logic [CW-1:0] bar_div_c;
  logic [2:0]    bar_c;

  // Bar index for the current column, clipped for leftover pixels.
  always_comb begin
    bar_div_c = h_cnt / CW'(BAR_W);
    bar_c     = (bar_div_c > CW'(NUM_BARS - 1)) ? 3'd7 : 3'(bar_div_c);
  end
`endif

  // Undelayed control terms; idle while stopped.
  always_comb begin
    raw_c = CTL_IDLE;
    if (running) begin
      raw_c.de          = h_act_c && v_act_c;
      raw_c.hs          = h_sync_c ? HS_POL : ~HS_POL;
      raw_c.vs          = v_sync_c ? VS_POL : ~VS_POL;
      raw_c.h_blank     = !h_act_c;
      raw_c.v_blank     = !v_act_c;
      raw_c.frame_start = (h_cnt == '0) && (v_cnt == '0);
      raw_c.line_start  = (h_cnt == '0) && v_act_c;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
      raw_c.bar         = bar_c;
`endif
    end
  end

  // REQ_LEAD+1 stage delay line; flushed to idle while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= CTL_IDLE;
    end else if (!enable) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= CTL_IDLE;
    end else begin
      pipe_q[0] <= raw_c;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Control word for the cycle in which the requested pixel is on r/g/b.
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  logic [2:0] tap_bar_c;
`endif
  if (REQ_LEAD == 0) begin : g_tap_raw
    assign tap_de_c  = raw_c.de;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    assign tap_bar_c = raw_c.bar;
`endif
  end else begin : g_tap_pipe
    assign tap_de_c  = pipe_q[REQ_LEAD-1].de;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    assign tap_bar_c = pipe_q[REQ_LEAD-1].bar;
`endif
  end

  // Pixel source: external data or colour bars.
  always_comb begin
    pix_c = {r, g, b};
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    if (tp_sel) pix_c = COLOUR_BARS[tap_bar_c];
`endif
  end

`ifndef VIDEO_TIMING_TEST_PATTERN_EN
  logic tp_sel_unused;
  assign tp_sel_unused = tp_sel;
`endif

  // Pixel register, forced black outside the active window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else if (!enable) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= tap_de_c ? pix_c : '0;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_de      = pipe_q[DEPTH-1].de;
  assign vga_hs      = pipe_q[DEPTH-1].hs;
  assign vga_vs      = pipe_q[DEPTH-1].vs;
  assign vga_h_blank = pipe_q[DEPTH-1].h_blank;
  assign vga_v_blank = pipe_q[DEPTH-1].v_blank;
  assign frame_start = pipe_q[DEPTH-1].frame_start;
  assign line_start  = pipe_q[DEPTH-1].line_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 16x8 raster (active 8x4).
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int unsigned CW = 12;
  localparam int HT = 16;
  localparam int VT = 8;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, enable, tp_sel;
  logic [7:0]    r, g, b;
  logic          req;
  logic [CW-1:0] req_x, req_y;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_de, vga_h_blank, vga_v_blank;
  logic          frame_start, line_start;

  video_timing_gen #(
    .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(2), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .r(r), .g(g), .b(b), .tp_sel(tp_sel),
    .req(req), .req_x(req_x), .req_y(req_y),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_h_blank(vga_h_blank), .vga_v_blank(vga_v_blank),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic de, hs, vs, hb, vb, fs, ls;
    logic [7:0] x;
  } vrec_t;

  localparam vrec_t IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1,
                             fs: 1'b0, ls: 1'b0, x: 8'h00};

  typedef struct {
    logic rst, en, tp;
    int   cycles;
    int   n_req, n_de, n_fs, n_ls;
  } phase_t;

  phase_t      ph [6];
  logic [23:0] bars [8];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference raster state and output scoreboard.
  bit          m_run;
  int          m_h, m_v;
  vrec_t       q [$];
  vrec_t       raw_cur, exp_v;
  logic [23:0] exp_rgb;
  logic [7:0]  xh1, xh2;
  int          c_req, c_de, c_fs, c_ls;
  logic [55:0] act_vec, exp_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
  endtask

  function automatic vrec_t model_raw();
    vrec_t v;
    v = IDLE;
    if (m_run) begin
      v.de = (m_h < 8) && (m_v < 4);
      v.hs = !((m_h >= 10) && (m_h < 13));
      v.vs = !((m_v >= 5) && (m_v < 7));
      v.hb = (m_h >= 8);
      v.vb = (m_v >= 4);
      v.fs = (m_h == 0) && (m_v == 0);
      v.ls = (m_h == 0) && (m_v < 4);
      v.x  = v.de ? 8'(m_h) : 8'h00;
    end
    return v;
  endfunction

  task automatic model_clear();
    m_run   = 1'b0;
    m_h     = 0;
    m_v     = 0;
    q       = '{IDLE, IDLE};
    exp_v   = IDLE;
    exp_rgb = '0;
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    //          rst   en    tp    cyc  req de  fs ls
    ph[0] = '{1'b1, 1'b1, 1'b0,   4,   0,  0, 0, 0};
    ph[1] = '{1'b0, 1'b1, 1'b0, 294,  85, 82, 3, 11};
    ph[2] = '{1'b0, 1'b0, 1'b0,  10,   1,  1, 0, 0};
    ph[3] = '{1'b0, 1'b1, 1'b1, 130,  33, 32, 1, 4};
    ph[4] = '{1'b1, 1'b1, 1'b0,   1,   0,  0, 0, 0};
    ph[5] = '{1'b0, 1'b1, 1'b0,  40,  23, 20, 1, 3};

    reset = 1'b1; enable = 1'b0; tp_sel = 1'b0;
    r = '0; g = '0; b = '0;
    model_clear();
    raw_cur = IDLE;
    xh1 = '0; xh2 = '0;
    repeat (2) @(posedge clk);

    for (int p = 0; p < 6; p++) begin
      c_req = 0; c_de = 0; c_fs = 0; c_ls = 0;
      for (int i = 0; i < ph[p].cycles; i++) begin
        @(posedge clk);
        #1;
        // Expected effect of the edge, using the inputs it saw.
        if (reset || !enable) begin
          model_clear();
        end else begin
          q.push_back(raw_cur);
          exp_v   = q.pop_front();
          exp_rgb = !exp_v.de ? 24'h0 : (TP && tp_sel) ? bars[exp_v.x[2:0]] : {r, g, b};
          if (!m_run) begin
            m_run = 1'b1;
          end else begin
            m_h++;
            if (m_h == HT) begin
              m_h = 0;
              m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
          end
        end

        reset  = ph[p].rst;
        enable = ph[p].en;
        tp_sel = ph[p].tp;
        if (reset) model_clear();
        raw_cur = model_raw();
        r   = xh2;
        g   = 8'($urandom);
        b   = 8'($urandom);
        xh2 = xh1;
        xh1 = raw_cur.x;

        @(negedge clk);
        act_vec = {req, req_x, req_y, vga_r, vga_g, vga_b,
                   vga_hs, vga_vs, vga_de, vga_h_blank, vga_v_blank, frame_start, line_start};
        exp_vec = {raw_cur.de,
                   raw_cur.de ? 12'(m_h) : 12'h0,
                   raw_cur.de ? 12'(m_v) : 12'h0,
                   exp_rgb,
                   exp_v.hs, exp_v.vs, exp_v.de, exp_v.hb, exp_v.vb, exp_v.fs, exp_v.ls};
        check($sformatf("cycle p%0d i%0d", p, i), 64'(act_vec), 64'(exp_vec));

        c_req += int'(req);
        c_de  += int'(vga_de);
        c_fs  += int'(frame_start);
        c_ls  += int'(line_start);

        // Hand-derived corner points.
        if (p == 1 && i == 0) check("idle_after_release", 64'(req), 64'd0);
        if (p == 1 && i == 1) check("first_req_origin", 64'({req, req_x, req_y}), 64'({1'b1, 12'd0, 12'd0}));
        if (p == 1 && i == 3) check("de_not_yet", 64'(vga_de), 64'd0);
        if (p == 1 && i == 4) check("de_first", 64'({vga_de, vga_r}), 64'({1'b1, 8'd0}));
        if (p == 1 && i == 11) check("de_last_px", 64'({vga_de, vga_r}), 64'({1'b1, 8'd7}));
        if (p == 1 && i == 12) check("de_line_end", 64'(vga_de), 64'd0);
        if (p == 2 && i == 0) check("drop_point", 64'({req, req_x, req_y}), 64'({1'b1, 12'd5, 12'd2}));
        if (p == 2 && i == 1) check("gap_idle", 64'({req, vga_de, vga_hs, vga_vs, vga_h_blank, vga_v_blank}),
                                    64'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}));
        if (p == 3 && i == 0) check("no_req_on_enable", 64'(req), 64'd0);
        if (p == 3 && i == 1) check("restart_origin", 64'({req, req_x, req_y}), 64'({1'b1, 12'd0, 12'd0}));
        if (p == 4 && i == 0)
          check("reset_idle", 64'(act_vec),
                64'({1'b0, 12'd0, 12'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
      end
      check($sformatf("req_count p%0d", p), 64'(c_req), 64'(ph[p].n_req));
      check($sformatf("de_count p%0d", p),  64'(c_de),  64'(ph[p].n_de));
      check($sformatf("fs_count p%0d", p),  64'(c_fs),  64'(ph[p].n_fs));
      check($sformatf("ls_count p%0d", p),  64'(c_ls),  64'(ph[p].n_ls));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
